// File: rtl/conway_pkg.sv
//------------------------------------------------------------------------------
// conway_pkg : shared state type and default board dimensions
// Revision   : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package conway_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        COMMIT  = 2'd2
    } gen_state_t;

    localparam int DEFAULT_ROWS  = 8;
    localparam int DEFAULT_GEN_W = 16;

endpackage

`default_nettype wire

// File: rtl/row_decoder.sv
//------------------------------------------------------------------------------
// row_decoder : binary row index to one-hot enable; out-of-range gives zero
// Revision    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module row_decoder #(
    parameter int  ROWS  = 8,
    localparam int IDX_W = $clog2(ROWS)
) (
    input  logic             en,
    input  logic [IDX_W-1:0] idx,
    output logic [ROWS-1:0]  onehot
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (en && (idx == IDX_W'(i))) begin
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/gen_ctrl.sv
//------------------------------------------------------------------------------
// gen_ctrl : Game-of-Life generation sequencer (compute, commit, host loads)
//            Optional generation counter enabled by macro GEN_COUNT_EN.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module gen_ctrl
    import conway_pkg::*;
#(
    parameter int  ROWS  = DEFAULT_ROWS,
    parameter int  GEN_W = DEFAULT_GEN_W,
    localparam int ROW_W = $clog2(ROWS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             run,
    input  logic             host_we,
    input  logic [ROW_W-1:0] host_row,
    output logic             host_ack,
    output logic             busy,
    output logic             done,
    output logic [ROW_W-1:0] row_sel,
    output logic [ROWS-1:0]  shadow_we,
    output logic [ROWS-1:0]  live_we,
    output logic             load_sel
`ifdef GEN_COUNT_EN
    ,
    output logic [GEN_W-1:0] gen_count
`endif
);

    gen_state_t       r_state, w_state_nxt;
    logic [ROW_W-1:0] r_row, w_row_nxt;
    logic             r_pending, w_pending_nxt;
    logic             r_done;
    logic             w_shadow_en;
    logic             w_host_en;
    logic             w_commit;
    logic [ROWS-1:0]  w_host_dec;

    always_comb begin
        w_state_nxt   = r_state;
        w_row_nxt     = r_row;
        w_pending_nxt = r_pending;
        host_ack      = 1'b0;
        row_sel       = '0;
        load_sel      = 1'b0;
        w_shadow_en   = 1'b0;
        w_host_en     = 1'b0;
        w_commit      = 1'b0;

        case (r_state)
            IDLE: begin
                // A host write holds off the generation; a coincident start is remembered.
                if (host_we) begin
                    host_ack  = 1'b1;
                    row_sel   = host_row;
                    load_sel  = 1'b1;
                    w_host_en = 1'b1;
                    if (start) begin
                        w_pending_nxt = 1'b1;
                    end
                end else if (start || run || r_pending) begin
                    w_state_nxt   = COMPUTE;
                    w_row_nxt     = '0;
                    w_pending_nxt = 1'b0;
                end
            end
            COMPUTE: begin
                row_sel     = r_row;
                w_shadow_en = 1'b1;
                if (r_row == ROW_W'(ROWS - 1)) begin
                    w_state_nxt = COMMIT;
                end else begin
                    w_row_nxt = r_row + ROW_W'(1);
                end
            end
            COMMIT: begin
                w_commit    = 1'b1;
                w_row_nxt   = '0;
                w_state_nxt = run ? COMPUTE : IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // No write strobe may escape while reset is held.
        if (reset) begin
            host_ack    = 1'b0;
            row_sel     = '0;
            load_sel    = 1'b0;
            w_shadow_en = 1'b0;
            w_host_en   = 1'b0;
            w_commit    = 1'b0;
        end
    end

    row_decoder #(.ROWS(ROWS)) u_shadow_dec (
        .en     (w_shadow_en),
        .idx    (r_row),
        .onehot (shadow_we)
    );

    row_decoder #(.ROWS(ROWS)) u_host_dec (
        .en     (w_host_en),
        .idx    (host_row),
        .onehot (w_host_dec)
    );

    assign live_we = w_commit ? {ROWS{1'b1}} : w_host_dec;
    assign busy    = (r_state != IDLE);
    assign done    = r_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_row     <= '0;
            r_pending <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_row     <= w_row_nxt;
            r_pending <= w_pending_nxt;
            r_done    <= (r_state == COMMIT);
        end
    end

`ifdef GEN_COUNT_EN
    logic [GEN_W-1:0] r_gen_count;

    // Any in-range host load starts a new pattern, so the count restarts.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_gen_count <= '0;
        end else if (w_commit) begin
            r_gen_count <= r_gen_count + GEN_W'(1);
        end else if (|w_host_dec) begin
            r_gen_count <= '0;
        end
    end

    assign gen_count = r_gen_count;
`endif

endmodule

`default_nettype wire
